synaptic_weight_accumulator: RTL and testbench
==============================================

# synaptic_weight_accumulator

Per-timestep accumulator for the 30-neuron accelerator. It sits directly upstream of the per-neuron `potential_adderNN` stages. During a timestep it receives a stream of synaptic weight events (target neuron index, IEEE-754 single-precision weight) and sums them per neuron. At timestep end it presents one stable accumulated `input_weightNN` word per neuron on a flat bus, held until the adder stage acknowledges.

## Interface
Parameters:
- `NEURONS`, default 30: number of accumulators.
- `IDX_W`, default 5: width of the neuron index.

Ports (one clock; reset is synchronous and active-high):
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `ts_start` input 1: opens a timestep; zeroes all accumulators. Honoured only in IDLE.
- `ts_end` input 1: closes the timestep. Honoured only in ACCUM.
- `ev_valid` input 1: weight event present.
- `ev_ready` output 1: accepting events.
- `ev_neuron` input IDX_W: target neuron index.
- `ev_weight` input 32: FP32 weight.
- `input_weight_flat` output NEURONS*32: accumulator k occupies bits [32k+31:32k].
- `weights_valid` output 1: flat bus is final and stable.
- `weights_ack` input 1: adder stage has consumed the weights.
- `fp_err` output 1: sticky; the FP adder raised Exception this timestep.
- `idx_err` output 1: sticky; an event had `ev_neuron >= NEURONS`.

## Operation
- **FSM states:** IDLE, ACCUM, DRAIN, HOLD. Reset state is IDLE.
- **IDLE:**
  - `ts_start` causes the following on the next edge: all accumulators become 32'h00000000, `fp_err` and `idx_err` clear, and the state goes to ACCUM.
  - All other inputs are ignored.
- **ACCUM:**
  - `ev_ready = !ts_end`. An event is accepted on an edge where `ev_valid && ev_ready`.
  - `ts_end` moves the state to DRAIN. If `ts_start` and `ts_end` are high together, `ts_end` wins and `ts_start` is ignored.
- **DRAIN:** lasts exactly 2 cycles while the pipeline retires, then the state goes to HOLD. `ev_ready` is 0.
- **HOLD:** `weights_valid = 1` and the bus is frozen. `weights_ack` returns the state to IDLE. `ts_start` in HOLD is ignored.
- **Pipeline (3 stages):**
  - S1 registers the accepted event (valid, idx, weight).
  - S2 computes sum = operand + S1.weight using the FP adder (subtract select 0). If S3 holds a valid write to the same idx, the operand is S3.sum (forwarding); otherwise it is acc[S1.idx].
  - S3 registers (valid, idx, sum) and writes acc[idx] on the next edge.
- **Out-of-range index** (idx >= NEURONS): the event is accepted, the write is suppressed, and `idx_err` is set.
- **Adder Exception:** any Exception on a valid S2 operation sets `fp_err`. The sum is still written.
- **Mid-operation reset:** `RST` in any state behaves like power-on reset. In-flight pipeline entries are discarded.

## Timing
- **Reset values:**
  - state IDLE
  - `ev_ready` 0
  - `weights_valid` 0
  - `fp_err` 0
  - `idx_err` 0
  - all accumulators 0 (so `input_weight_flat` is 0)
  - pipeline valids 0
- **Event latency:** an event accepted at edge k is visible in `input_weight_flat` after edge k+2.
- **Throughput:** one event per cycle. Back-to-back events to the same neuron are summed exactly through forwarding.
- **Timestep close:** `ts_end` sampled high in cycle t gives DRAIN in cycles t+1 and t+2, and `weights_valid` rises in cycle t+3.
- **Hold/release:** `weights_valid` falls the cycle after `weights_ack` is sampled. The earliest next `ts_start` is in that same following cycle (IDLE).
- **Output registering:** `ev_ready` is combinational from state and `ts_end`. All other outputs are registered.

## Structure
- Shared include/package holds the FSM state localparams (2-bit), `FP_ZERO` = 32'h00000000, and default `NEURONS`/`IDX_W`.
- Reuses the existing `Addition_Subtraction` (one instance in S2). No new sub-module.
- Accumulators are a register array, not RAM, so all NEURONS words can drive the flat bus simultaneously.

## Test plan
- **Reset and open:** reset, then `ts_start` -> all 30 words 0, state ACCUM, `ev_ready` = 1 the next cycle.
- **Single event:** event (3, 32'h3F800000 = 1.0) then `ts_end` -> word 3 = 32'h3F800000, all others 0, `weights_valid` exactly 3 cycles after `ts_end`.
- **Forwarding:** back-to-back events to neuron 7 with 1.0, 2.0, 0.5 -> word 7 = 32'h40600000 (3.5).
- **Interleaving:** events to neurons 0, 29, 0, 29 each with 1.0 -> words 0 and 29 = 32'h40000000.
- **Error flags:** `ev_neuron` = 30 -> `idx_err` = 1, no word changes. Weight 32'h7F800000 (+inf) into neuron 1 -> `fp_err` = 1.
- **Boundaries:**
  - `ts_start` and `ts_end` together in ACCUM -> DRAIN.
  - `RST` during DRAIN -> IDLE with all outputs 0.
  - `weights_ack` in HOLD -> `weights_valid` low the next cycle, and a new `ts_start` re-zeroes the bus.

Source files
------------

// File: rtl/synaptic_weight_accumulator_pkg.sv
// Shared types and constants for the synaptic weight accumulator.
package synaptic_weight_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          NEURONS_DEF = 30;
  localparam int          IDX_W_DEF   = 5;
  // Cycles spent in DRAIN while the three-stage pipeline retires.
  localparam int          DRAIN_LEN   = 2;

endpackage

// File: rtl/synaptic_weight_accumulator_if.sv
// Event stream, timestep control and flat weight bus toward the adder stage.
interface synaptic_weight_accumulator_if
  import synaptic_weight_accumulator_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int IDX_W   = IDX_W_DEF
);
  logic                    ts_start;
  logic                    ts_end;
  logic                    ev_valid;
  logic                    ev_ready;
  logic [IDX_W-1:0]        ev_neuron;
  logic [31:0]             ev_weight;
  logic [NEURONS*32-1:0]   input_weight_flat;
  logic                    weights_valid;
  logic                    weights_ack;
  logic                    fp_err;
  logic                    idx_err;

  modport master (
    output ts_start, ts_end, ev_valid, ev_neuron, ev_weight, weights_ack,
    input  ev_ready, input_weight_flat, weights_valid, fp_err, idx_err
  );

  modport slave (
    input  ts_start, ts_end, ev_valid, ev_neuron, ev_weight, weights_ack,
    output ev_ready, input_weight_flat, weights_valid, fp_err, idx_err
  );
endinterface

// File: rtl/Addition_Subtraction.sv
// Combinational FP32 adder/subtractor, round-to-nearest-even.
// Exception flags an Inf/NaN operand or a result that overflows to infinity.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);
  logic [31:0] b_eff, x, y;
  logic [9:0]  ex, ey, e_norm;
  logic [7:0]  d;
  logic [26:0] mx, my, my_sh, norm;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [30:0] packed_r;
  logic        special, ovf;

  // Align the smaller operand, add/subtract, normalise and round.
  always_comb begin
    b_eff = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    if (a_operand[30:0] >= b_eff[30:0]) begin
      x = a_operand;
      y = b_eff;
    end else begin
      x = b_eff;
      y = a_operand;
    end
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my = {y[30:23] != 8'd0, y[22:0], 3'b000};
    d  = 8'(ex - ey);
    if (d >= 8'd27) my_sh = {26'd0, |my};
    else            my_sh = (my >> d) | {26'd0, |(my & ~({27{1'b1}} << d))};
    s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    if (s[27]) begin
      norm   = {s[27:2], s[1] | s[0]};
      e_norm = ex + 10'd1;
    end else if ({5'd0, lz} >= ex) begin
      // Result underflows to a subnormal: shift only down to the minimum exponent.
      norm   = s[26:0] << (ex - 10'd1);
      e_norm = 10'd1;
    end else begin
      norm   = s[26:0] << lz;
      e_norm = ex - {5'd0, lz};
    end
    // Rounding carry ripples from the fraction into the exponent field.
    packed_r = {(norm[26] ? e_norm[7:0] : 8'd0), norm[25:3]}
             + {30'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
    special   = (&a_operand[30:23]) | (&b_operand[30:23]);
    ovf       = !special && ((e_norm >= 10'd255) || (packed_r[30:23] == 8'hFF));
    Exception = special | ovf;
    if (special)          result = x;
    else if (ovf)         result = {x[31], 8'hFF, 23'd0};
    else if (s == 28'd0)  result = 32'd0;
    else                  result = {x[31], packed_r};
  end
endmodule

// File: rtl/synaptic_weight_accumulator.sv
// Per-timestep FP32 weight accumulator feeding the per-neuron potential adders.
//
// state | meaning
// IDLE  | waiting for ts_start; bus shows last results
// ACCUM | accepting weight events into the pipeline
// DRAIN | two cycles letting in-flight events reach the accumulators
// HOLD  | bus final, weights_valid high until weights_ack
module synaptic_weight_accumulator
  import synaptic_weight_accumulator_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input logic CLK,
  input logic RST,
  synaptic_weight_accumulator_if.slave bus
);
  state_t                state, state_next;
  logic [1:0]            drain_cnt;
  logic                  ev_ready, accept, zero_acc;
  logic                  weights_valid_q, fp_err_q, idx_err_q;
  logic                  s1_valid, s3_valid, s1_in_range;
  logic [IDX_W-1:0]      s1_idx, s3_idx;
  logic [31:0]           s1_weight, s3_sum, operand, sum;
  logic                  add_exc;
  logic [31:0]           acc [NEURONS];
  logic [NEURONS*32-1:0] flat;

  // Next-state and event handshake decode.
  always_comb begin
    state_next = state;
    ev_ready   = 1'b0;
    zero_acc   = 1'b0;
    case (state)
      ST_IDLE: if (bus.ts_start) begin
        state_next = ST_ACCUM;
        zero_acc   = 1'b1;
      end
      ST_ACCUM: begin
        ev_ready = !bus.ts_end;
        if (bus.ts_end) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == 2'd0) state_next = ST_HOLD;
      ST_HOLD:  if (bus.weights_ack) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register, drain down-counter and registered valid flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= ST_IDLE;
      drain_cnt       <= 2'd0;
      weights_valid_q <= 1'b0;
    end else begin
      state           <= state_next;
      weights_valid_q <= (state_next == ST_HOLD);
      if (state_next == ST_DRAIN && state != ST_DRAIN) drain_cnt <= 2'(DRAIN_LEN - 1);
      else if (drain_cnt != 2'd0)                    drain_cnt <= drain_cnt - 2'd1;
    end
  end

  assign accept      = ev_ready & bus.ev_valid;
  assign s1_in_range = ({1'b0, s1_idx} < (IDX_W+1)'(NEURONS));

  // S2 operand select: forward the sum still sitting in S3 for the same neuron.
  always_comb begin
    operand = FP_ZERO;
    for (int k = 0; k < NEURONS; k++) if (s1_idx == IDX_W'(k)) operand = acc[k];
    if (s3_valid && s3_idx == s1_idx) operand = s3_sum;
  end

  Addition_Subtraction u_add (
    .a_operand  (operand),
    .b_operand  (s1_weight),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (sum)
  );

  // S1/S3 pipeline registers and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_weight <= FP_ZERO;
      s3_valid  <= 1'b0;
      s3_idx    <= '0;
      s3_sum    <= FP_ZERO;
      fp_err_q  <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      s1_valid  <= accept;
      s1_idx    <= bus.ev_neuron;
      s1_weight <= bus.ev_weight;
      s3_valid  <= s1_valid && s1_in_range;
      s3_idx    <= s1_idx;
      s3_sum    <= sum;
      if (zero_acc) begin
        fp_err_q  <= 1'b0;
        idx_err_q <= 1'b0;
      end else if (s1_valid) begin
        if (add_exc)      fp_err_q  <= 1'b1;
        if (!s1_in_range) idx_err_q <= 1'b1;
      end
    end
  end

  // Accumulator array: cleared at timestep open, written from S3.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NEURONS; k++) begin
      if (RST || zero_acc)                     acc[k] <= FP_ZERO;
      else if (s3_valid && s3_idx == IDX_W'(k)) acc[k] <= s3_sum;
    end
  end

  // Flatten the accumulators onto the output bus.
  always_comb begin
    flat = '0;
    for (int k = 0; k < NEURONS; k++) flat[32*k +: 32] = acc[k];
  end

  assign bus.ev_ready          = ev_ready;
  assign bus.input_weight_flat = flat;
  assign bus.weights_valid     = weights_valid_q;
  assign bus.fp_err            = fp_err_q;
  assign bus.idx_err           = idx_err_q;
endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Directed plus randomized bench; expected words come from exact quarter-unit sums.
module tb_synaptic_weight_accumulator;
  localparam int N = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synaptic_weight_accumulator_if #(.NEURONS(N), .IDX_W(5)) bus ();

  synaptic_weight_accumulator #(.NEURONS(N), .IDX_W(5)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int model_q [N];   // per-neuron sum in units of 0.25

  // Exact FP32 encoding of q/4 for small integers q.
  function automatic logic [31:0] enc(input int q);
    int mag, p;
    logic [31:0] r;
    if (q == 0) return 32'h0;
    mag = (q < 0) ? -q : q;
    p = 0;
    for (int i = 0; i < 30; i++) if (mag >= (1 << i)) p = i;
    r[31]    = (q < 0);
    r[30:23] = 8'(p - 2 + 127);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag);
    for (int k = 0; k < N; k++)
      chk_word($sformatf("%s_w%0d", tag, k), bus.input_weight_flat[32*k +: 32], enc(model_q[k]));
  endtask

  task automatic open_ts();
    bus.ts_start = 1'b1;
    tick();
    bus.ts_start = 1'b0;
    for (int k = 0; k < N; k++) model_q[k] = 0;
    chk_bit("open_ready", bus.ev_ready, 1'b1);
  endtask

  task automatic send_raw(input int idx, input logic [31:0] w);
    bus.ev_valid  = 1'b1;
    bus.ev_neuron = 5'(idx);
    bus.ev_weight = w;
    tick();
    bus.ev_valid  = 1'b0;
  endtask

  task automatic send(input int idx, input int q);
    send_raw(idx, enc(q));
    if (idx < N) model_q[idx] += q;
  endtask

  // ts_end (optionally with ts_start) for one cycle; weights_valid must rise 3 cycles later.
  task automatic close_ts(input logic with_start);
    int n;
    bus.ts_end   = 1'b1;
    bus.ts_start = with_start;
    #1;
    chk_bit("close_ready_low", bus.ev_ready, 1'b0);
    tick();
    bus.ts_end   = 1'b0;
    bus.ts_start = 1'b0;
    n = 1;
    while (!bus.weights_valid && n < 10) begin
      tick();
      n++;
    end
    chk_word("close_latency", 32'(n), 32'd3);
  endtask

  task automatic release_ts();
    bus.weights_ack = 1'b1;
    tick();
    bus.weights_ack = 1'b0;
    chk_bit("release_wv", bus.weights_valid, 1'b0);
  endtask

  initial begin
    int idx, q, last;
    logic exp_ie;

    rst = 1'b1;
    bus.ts_start = 1'b0; bus.ts_end = 1'b0; bus.ev_valid = 1'b0;
    bus.ev_neuron = '0; bus.ev_weight = '0; bus.weights_ack = 1'b0;
    for (int k = 0; k < N; k++) model_q[k] = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk_bit("rst_ready", bus.ev_ready, 1'b0);
    chk_bit("rst_wv", bus.weights_valid, 1'b0);
    chk_bit("rst_fp", bus.fp_err, 1'b0);
    chk_bit("rst_idx", bus.idx_err, 1'b0);
    check_words("rst");

    // Single event, with latency check.
    open_ts();
    check_words("open");
    send(3, 4);
    tick();
    chk_word("lat_k1", bus.input_weight_flat[32*3 +: 32], 32'h0);
    tick();
    chk_word("lat_k2", bus.input_weight_flat[32*3 +: 32], 32'h3F80_0000);
    close_ts(1'b0);
    check_words("single");
    // ts_start in HOLD must be ignored.
    bus.ts_start = 1'b1;
    tick();
    bus.ts_start = 1'b0;
    chk_bit("hold_start_wv", bus.weights_valid, 1'b1);
    check_words("hold_start");
    release_ts();

    // Forwarding and interleaving.
    open_ts();
    send(7, 4); send(7, 8); send(7, 2);
    send(0, 4); send(29, 4); send(0, 4); send(29, 4);
    close_ts(1'b0);
    chk_word("fwd_w7", bus.input_weight_flat[32*7 +: 32], 32'h4060_0000);
    chk_word("ilv_w0", bus.input_weight_flat[32*0 +: 32], 32'h4000_0000);
    chk_word("ilv_w29", bus.input_weight_flat[32*29 +: 32], 32'h4000_0000);
    check_words("fwd");
    chk_bit("fwd_idx", bus.idx_err, 1'b0);
    release_ts();

    // Out-of-range index, then ts_start together with ts_end.
    open_ts();
    send(5, -6);
    send(30, 4);
    tick();
    chk_bit("oor_idx", bus.idx_err, 1'b1);
    close_ts(1'b1);
    check_words("oor");
    chk_bit("oor_fp", bus.fp_err, 1'b0);
    release_ts();

    // Randomized timesteps.
    last = 0;
    for (int t = 0; t < 4; t++) begin
      open_ts();
      exp_ie = 1'b0;
      for (int n = 0; n < 24; n++) begin
        if ($urandom_range(0, 3) == 0) tick();
        idx = ($urandom_range(0, 2) == 0) ? last : int'($urandom_range(0, 31));
        q   = int'($urandom_range(0, 32)) - 16;
        send(idx, q);
        if (idx >= N) exp_ie = 1'b1;
        last = idx;
      end
      close_ts(1'b0);
      check_words($sformatf("rnd%0d", t));
      chk_bit("rnd_idx", bus.idx_err, exp_ie);
      chk_bit("rnd_fp", bus.fp_err, 1'b0);
      release_ts();
    end

    // Release then immediate reopen re-zeroes the bus.
    open_ts();
    send(12, 10);
    close_ts(1'b0);
    check_words("pre_reopen");
    bus.weights_ack = 1'b1;
    tick();
    bus.weights_ack = 1'b0;
    chk_bit("reopen_wv", bus.weights_valid, 1'b0);
    chk_word("reopen_keep", bus.input_weight_flat[32*12 +: 32], enc(10));
    open_ts();
    check_words("reopen");

    // Reset while draining discards in-flight events.
    send(4, 4);
    bus.ts_end = 1'b1;
    tick();
    bus.ts_end = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) model_q[k] = 0;
    chk_bit("drst_ready", bus.ev_ready, 1'b0);
    chk_bit("drst_wv", bus.weights_valid, 1'b0);
    check_words("drst");
    repeat (4) tick();
    chk_bit("drst_stay_idle", bus.weights_valid, 1'b0);
    check_words("drst_late");

    // Infinity raises fp_err.
    open_ts();
    send_raw(1, 32'h7F80_0000);
    close_ts(1'b0);
    chk_word("inf_w1", bus.input_weight_flat[32*1 +: 32], 32'h7F80_0000);
    chk_word("inf_w0", bus.input_weight_flat[32*0 +: 32], 32'h0);
    chk_bit("inf_fp", bus.fp_err, 1'b1);
    chk_bit("inf_idx", bus.idx_err, 1'b0);
    release_ts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
